// File: rtl/im_loader_ctrl.sv
// Writable 256x13 instruction store for the 8-bit CPU. A host streams a program in over
// valid/ready while the CPU is held in reset, then the CPU runs and fetches from it.
module im_loader_ctrl #(
    parameter int AW = 8,
    parameter int DW = 13
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          load_req,
    input  logic          run_req,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    input  logic [AW-1:0] pc,
    output logic [DW-1:0] instr,
    output logic          cpu_n_reset,
    output logic [1:0]    state,
    output logic [AW:0]   load_count,
    output logic          err
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    state_t        cur_state;
    logic [AW-1:0] wr_ptr;
    logic          loaded;
    logic          xfer;
    logic [DW-1:0] mem [DEPTH];

    assign xfer     = ld_valid && (cur_state == ST_LOAD);
    assign ld_ready = (cur_state == ST_LOAD);
    assign err      = (cur_state == ST_ERR);
    assign state    = cur_state;
    assign instr    = (cur_state == ST_RUN) ? mem[pc] : '0;

    // Program store has no reset so a partial load leaves earlier contents in place.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cur_state   <= ST_HALT;
            cpu_n_reset <= 1'b0;
            loaded      <= 1'b0;
            wr_ptr      <= '0;
            load_count  <= '0;
        end else begin
            case (cur_state)
                ST_HALT: begin
                    if (load_req) begin
                        cur_state <= ST_LOAD;
                        wr_ptr    <= '0;
                    end else if (run_req && loaded) begin
                        cur_state   <= ST_RUN;
                        cpu_n_reset <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (ld_last) begin
                            cur_state   <= ST_RUN;
                            cpu_n_reset <= 1'b1;
                            loaded      <= 1'b1;
                            load_count  <= {1'b0, wr_ptr} + 1'b1;
                        end else if (wr_ptr == '1) begin
                            // Store is full and the host still has more words: abort.
                            cur_state  <= ST_ERR;
                            loaded     <= 1'b0;
                            load_count <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (load_req) begin
                        cur_state   <= ST_LOAD;
                        cpu_n_reset <= 1'b0;
                        wr_ptr      <= '0;
                    end
                end
                ST_ERR: begin
                    if (load_req) begin
                        cur_state <= ST_LOAD;
                        wr_ptr    <= '0;
                    end
                end
                default: begin
                    cur_state   <= ST_HALT;
                    cpu_n_reset <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/im_loader_ctrl.md
Name: im_loader_ctrl

Overview:
Program-load and run controller for the 8-bit CPU instruction memory: 256 x 13-bit words, each a 5-bit opcode followed by an 8-bit operand. It owns a writable 256x13 instruction store and streams a program into it from a host over a valid/ready handshake. It holds the CPU in reset while loading, then releases it and serves instruction fetches from the CPU's 8-bit PC. It replaces the fixed-content instruction ROM at the CPU fetch port.

Parameters:
AW, 8, address width; depth = 2^AW = 256 words
DW, 13, instruction width ({opcode[4:0], operand[7:0]})

Ports:
clk  input  1  system clock, rising edge
n_reset  input  1  asynchronous active-low reset
load_req  input  1  request to (re)load program; sampled each cycle
run_req  input  1  request to start CPU from HALT
ld_valid  input  1  host word valid
ld_ready  output  1  controller accepts word
ld_data  input  DW  instruction word
ld_last  input  1  marks final word of program
pc  input  AW  CPU fetch address
instr  output  DW  fetched instruction
cpu_n_reset  output  1  active-low reset to CPU core, registered
state  output  2  HALT=00, LOAD=01, RUN=10, ERR=11
load_count  output  AW+1  words in last successful load (0..256)
err  output  1  overflow error flag

Behaviour:
- Reset (async, n_reset=0) forces the following.
  - state=HALT, cpu_n_reset=0, err=0, load_count=0.
  - Internal loaded flag=0 and wr_ptr=0.
  - Memory contents are not reset.
- ld_ready = (state==LOAD), decoded from the state register. err = (state==ERR).
- cpu_n_reset = 1 exactly while state==RUN, registered together with state.
- instr = mem[pc] combinationally when state==RUN; instr = 13'h0000 in every other state.
- A transfer occurs on a rising edge where ld_valid & ld_ready. ld_data/ld_last are don't-care otherwise.
- HALT:
  - load_req=1 -> LOAD; wr_ptr<=0.
  - Else run_req=1 and loaded=1 -> RUN.
  - Else run_req with loaded=0 is ignored; stay HALT.
  - load_req has priority over run_req.
- LOAD:
  - On each transfer: mem[wr_ptr]<=ld_data; wr_ptr<=wr_ptr+1.
  - Transfer with ld_last=1 -> RUN next cycle; loaded<=1; load_count<=wr_ptr+1 (9-bit, so 256 is representable). cpu_n_reset rises on that same edge.
  - Transfer at wr_ptr=255 with ld_last=0 -> ERR; loaded<=0; load_count<=0.
  - Words above the last written address keep stale contents.
  - load_req is ignored in LOAD, and ld_valid gaps simply stall the load.
- RUN:
  - load_req=1 -> LOAD on the next edge; wr_ptr<=0; cpu_n_reset falls on that edge.
  - run_req is ignored.
- ERR:
  - ld_ready=0, cpu_n_reset=0.
  - load_req=1 -> LOAD (err clears); wr_ptr<=0.
  - run_req is ignored.
- wr_ptr is AW bits wide. Wrap-around never occurs, because reaching 255 without last goes to ERR.
- Reset asserted mid-load:
  - Immediate return to HALT with loaded=0.
  - Words already written stay in memory, but run_req cannot start until a full reload completes.
- No CPU-side write path. pc changes have no effect outside RUN.

Test Plan:
- Reset values: assert n_reset=0 mid-cycle -> immediately state=00, cpu_n_reset=0, ld_ready=0, err=0, load_count=0, instr=0. Then run_req=1 for 3 cycles -> state stays 00.
- Basic load and run:
  - Stimulus: load_req, then stream 0x0E00, 0x0CCE, 0x1800, 0x1E01 back-to-back, with ld_last on the 4th word.
  - Required: state=10 and cpu_n_reset=1 on the edge after the 4th transfer; load_count=4.
  - Required fetches: pc=1 -> instr=0x0CCE; pc=3 -> instr=0x1E01.
- Backpressure/gaps: same program with ld_valid low on alternate cycles -> identical memory contents and load_count=4. No write occurs on cycles with ld_valid=0.
- Full depth: 256 words with data=addr and ld_last on the 256th -> RUN, load_count=256, pc=255 -> instr=0x00FF.
- Overflow:
  - Stimulus: 256 words with no ld_last.
  - Required: state=11, err=1, load_count=0, cpu_n_reset=0.
  - Then run_req -> stays 11. Then load_req -> state=01, err=0.
- Reload and reset mid-load:
  - In RUN, pulse load_req -> cpu_n_reset=0 next edge and instr=0. Load 2 words (0x1E00, 0x0001 last) -> RUN, load_count=2.
  - Then load_req, 1 word, then n_reset=0 -> HALT. run_req is then ignored (loaded=0).
